// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost renderer.
// State encoding, colour words and coordinate width.
package ghost_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    // Colours packed as {r,g,b}, 4 bits each
    localparam logic [11:0] SKY     = 12'h48C;
    localparam logic [11:0] GHOST   = 12'hFFF;
    localparam logic [11:0] DEAD_BG = 12'h800;

endpackage

// File: rtl/ghost_physics.sv
// Ghost vertical physics: vsync/flap edge detect, game FSM,
// velocity and committed top row, all updated once per frame.
module ghost_physics
    import ghost_pkg::*;
#(
    parameter int SCREEN_H = 900,
    parameter int GHOST_H  = 32,
    parameter int START_Y  = 434,
    parameter int GRAV     = 1,
    parameter int FLAP_V   = 10,
    parameter int MAX_V    = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_vsync,
    input  logic               i_flap,
    output state_t             o_state,
    output logic [COORD_W-1:0] o_ghost_y,
    output logic               o_hit
);

    localparam logic signed [7:0]  FLAP_VEL = 8'(-FLAP_V);
    localparam logic signed [7:0]  GRAV_VEL = 8'(GRAV);
    localparam logic signed [7:0]  MAX_VEL  = 8'(MAX_V);
    localparam logic signed [12:0] Y_FLOOR  = 13'(SCREEN_H - GHOST_H);

    state_t              r_state;
    logic [COORD_W-1:0]  r_ghost_y;
    logic signed [7:0]   r_vel;
    logic                r_hit;
    logic                r_vsync_d;
    logic                r_flap_d;
    logic                r_flap_pending;

    logic                w_tick;
    logic                w_flap_edge;
    logic                w_flap_any;
    logic signed [7:0]   w_vel_inc;
    logic signed [7:0]   w_vel_n;
    logic signed [12:0]  w_y_n;

    assign w_tick      = i_vsync & ~r_vsync_d;
    assign w_flap_edge = i_flap & ~r_flap_d;
    // An edge landing on the tick cycle still counts for that tick
    assign w_flap_any  = r_flap_pending | w_flap_edge;

    assign w_vel_inc = r_vel + GRAV_VEL;
    assign w_vel_n   = w_flap_any ? FLAP_VEL :
                       (w_vel_inc > MAX_VEL) ? MAX_VEL : w_vel_inc;
    assign w_y_n     = $signed({2'b00, r_ghost_y}) +
                       {{5{w_vel_n[7]}}, w_vel_n};

    // Edge detectors, flap latch and per-frame FSM update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_ghost_y      <= COORD_W'(START_Y);
            r_vel          <= '0;
            r_hit          <= 1'b0;
            r_vsync_d      <= 1'b0;
            r_flap_d       <= 1'b0;
            r_flap_pending <= 1'b0;
        end else begin
            r_vsync_d <= i_vsync;
            r_flap_d  <= i_flap;
            if (w_tick) begin
                r_flap_pending <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_flap_any) begin
                            r_state   <= ST_PLAY;
                            r_vel     <= FLAP_VEL;
                            r_ghost_y <= r_ghost_y - COORD_W'(FLAP_V);
                        end
                    end
                    ST_PLAY: begin
                        if (w_y_n < 0) begin
                            r_ghost_y <= '0;
                            r_vel     <= '0;
                        end else if (w_y_n >= Y_FLOOR) begin
                            r_ghost_y <= COORD_W'(SCREEN_H - GHOST_H);
                            r_vel     <= '0;
                            r_state   <= ST_DEAD;
                            r_hit     <= 1'b1;
                        end else begin
                            r_ghost_y <= w_y_n[COORD_W-1:0];
                            r_vel     <= w_vel_n;
                        end
                    end
                    ST_DEAD: begin
                        if (w_flap_any) begin
                            r_state   <= ST_IDLE;
                            r_ghost_y <= COORD_W'(START_Y);
                            r_vel     <= '0;
                            r_hit     <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end else if (w_flap_edge) begin
                r_flap_pending <= 1'b1;
            end
        end
    end

    assign o_state   = r_state;
    assign o_ghost_y = r_ghost_y;
    assign o_hit     = r_hit;

endmodule

// File: rtl/ghost_renderer.sv
// Ghost renderer top: physics plus sprite-over-background
// pixel colour, registered one clock after the coordinates.
module ghost_renderer
    import ghost_pkg::*;
#(
    parameter int SCREEN_H = 900,
    parameter int GHOST_X  = 200,
    parameter int GHOST_W  = 32,
    parameter int GHOST_H  = 32,
    parameter int START_Y  = 434,
    parameter int GRAV     = 1,
    parameter int FLAP_V   = 10,
    parameter int MAX_V    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] curr_x,
    input  logic [10:0] curr_y,
    input  logic        vsync,
    input  logic        flap,
    output logic [3:0]  draw_r,
    output logic [3:0]  draw_g,
    output logic [3:0]  draw_b,
    output logic [10:0] ghost_y,
    output logic        hit
);

    localparam logic [11:0] X_LO = 12'(GHOST_X);
    localparam logic [11:0] X_HI = 12'(GHOST_X + GHOST_W);

    state_t             w_state;
    logic [COORD_W-1:0] w_ghost_y;
    logic               w_hit;
    logic [11:0]        w_x12;
    logic [11:0]        w_y12;
    logic [11:0]        w_gy12;
    logic               w_in_ghost;
    logic [11:0]        r_draw;

    ghost_physics #(
        .SCREEN_H (SCREEN_H),
        .GHOST_H  (GHOST_H),
        .START_Y  (START_Y),
        .GRAV     (GRAV),
        .FLAP_V   (FLAP_V),
        .MAX_V    (MAX_V)
    ) u_phys (
        .clk       (clk),
        .rst       (rst),
        .i_vsync   (vsync),
        .i_flap    (flap),
        .o_state   (w_state),
        .o_ghost_y (w_ghost_y),
        .o_hit     (w_hit)
    );

    // Widen to 12 bits so ghost_y + GHOST_H cannot wrap
    assign w_x12  = {1'b0, curr_x};
    assign w_y12  = {1'b0, curr_y};
    assign w_gy12 = {1'b0, w_ghost_y};

    assign w_in_ghost = (w_x12 >= X_LO) && (w_x12 < X_HI) &&
                        (w_y12 >= w_gy12) &&
                        (w_y12 < w_gy12 + 12'(GHOST_H));

    // Pixel colour register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_draw <= '0;
        end else if (w_in_ghost) begin
            r_draw <= GHOST;
        end else if (w_state == ST_DEAD) begin
            r_draw <= DEAD_BG;
        end else begin
            r_draw <= SKY;
        end
    end

    assign draw_r  = r_draw[11:8];
    assign draw_g  = r_draw[7:4];
    assign draw_b  = r_draw[3:0];
    assign ghost_y = w_ghost_y;
    assign hit     = w_hit;

endmodule

// File: tb/tb_ghost_renderer.sv
// Bench for ghost_renderer: frame-level behavioural model
// compared every cycle, plus pinned literal scenarios.
module tb_ghost_renderer;

    localparam int P_SCREEN_H = 900;
    localparam int P_GX       = 200;
    localparam int P_GW       = 32;
    localparam int P_GH       = 32;
    localparam int P_START    = 434;
    localparam int P_FLAP     = 10;
    localparam int P_MAXV     = 12;
    localparam int P_FLOOR    = P_SCREEN_H - P_GH;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] curr_x;
    logic [10:0] curr_y;
    logic        vsync;
    logic        flap;
    logic [3:0]  draw_r;
    logic [3:0]  draw_g;
    logic [3:0]  draw_b;
    logic [10:0] ghost_y;
    logic        hit;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ghost_renderer dut (
        .clk     (clk),
        .rst     (rst),
        .curr_x  (curr_x),
        .curr_y  (curr_y),
        .vsync   (vsync),
        .flap    (flap),
        .draw_r  (draw_r),
        .draw_g  (draw_g),
        .draw_b  (draw_b),
        .ghost_y (ghost_y),
        .hit     (hit)
    );

    // Model: st 0=idle 1=play 2=dead; y/vel as plain ints
    typedef struct {
        int          st;
        int          y;
        int          vel;
        bit          pend;
        bit          vsd;
        bit          fd;
        logic [11:0] draw;
    } mdl_t;

    mdl_t m;
    bit   m_valid = 1'b0;

    function automatic mdl_t step(mdl_t c, logic r, logic v,
                                  logic f, logic [10:0] x,
                                  logic [10:0] y);
        mdl_t n = c;
        bit   tick;
        bit   pend;
        int   nv;
        int   ny;
        int   xi = int'(x);
        int   yi = int'(y);
        if (r) begin
            n.st = 0; n.y = P_START; n.vel = 0;
            n.pend = 0; n.vsd = 0; n.fd = 0; n.draw = '0;
            return n;
        end
        if (xi >= P_GX && xi < P_GX + P_GW &&
            yi >= c.y && yi < c.y + P_GH)
            n.draw = 12'hFFF;
        else if (c.st == 2)
            n.draw = 12'h800;
        else
            n.draw = 12'h48C;
        tick   = v && !c.vsd;
        pend   = c.pend || (f && !c.fd);
        n.vsd  = v;
        n.fd   = f;
        n.pend = tick ? 1'b0 : pend;
        if (tick) begin
            if (c.st == 0) begin
                if (pend) begin
                    n.st = 1; n.vel = -P_FLAP; n.y = c.y - P_FLAP;
                end
            end else if (c.st == 1) begin
                if (pend) nv = -P_FLAP;
                else nv = (c.vel + 1 > P_MAXV) ? P_MAXV : c.vel + 1;
                ny = c.y + nv;
                if (ny < 0) begin
                    n.y = 0; n.vel = 0;
                end else if (ny >= P_FLOOR) begin
                    n.y = P_FLOOR; n.vel = 0; n.st = 2;
                end else begin
                    n.y = ny; n.vel = nv;
                end
            end else begin
                if (pend) begin
                    n.st = 0; n.y = P_START; n.vel = 0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m       <= step(m, rst, vsync, flap, curr_x, curr_y);
        m_valid <= 1'b1;
    end

    task automatic check(input string name, input logic [11:0] got,
                         input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("draw", {draw_r, draw_g, draw_b}, m.draw);
            check("ghost_y", {1'b0, ghost_y}, 12'(m.y));
            check("hit", {11'd0, hit}, {11'd0, m.st == 2});
        end
    end

    function automatic int rx();
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 1279);
        return $urandom_range(P_GX - 10, P_GX + P_GW + 10);
    endfunction

    function automatic int ry();
        int lo = (m.y > 8) ? m.y - 8 : 0;
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 1100);
        return $urandom_range(lo, m.y + P_GH + 8);
    endfunction

    task automatic drv(input bit v, input bit f,
                       input int x, input int y);
        @(negedge clk);
        vsync  = v;
        flap   = f;
        curr_x = 11'(x);
        curr_y = 11'(y);
    endtask

    // len cycles, vsync high on the last two; flap pulses at fa/fb
    task automatic frame(input int len, input int fa, input int fb);
        for (int i = 0; i < len; i++)
            drv(i >= len - 2, (i == fa) || (i == fb), rx(), ry());
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst = 1'b1; vsync = 1'b0; flap = 1'b0;
        curr_x = '0; curr_y = '0;
        repeat (3) @(negedge clk);
        settle();
        check("rst_draw", {draw_r, draw_g, draw_b}, 12'h000);
        check("rst_y", {1'b0, ghost_y}, 12'd434);
        check("rst_hit", {11'd0, hit}, 12'd0);

        @(negedge clk);
        rst = 1'b0; curr_x = 11'd210; curr_y = 11'd440;
        settle();
        check("lit_ghost_px", {draw_r, draw_g, draw_b}, 12'hFFF);
        drv(0, 0, 100, 440);
        settle();
        check("lit_sky_px", {draw_r, draw_g, draw_b}, 12'h48C);

        frame(12, 3, -1); settle();
        check("first_flap", {1'b0, ghost_y}, 12'd424);
        frame(12, -1, -1); settle();
        check("fall_1", {1'b0, ghost_y}, 12'd415);
        frame(12, -1, -1); settle();
        check("fall_2", {1'b0, ghost_y}, 12'd407);

        k = 0;
        while (hit !== 1'b1 && k < 200) begin
            frame(10, -1, -1); settle(); k++;
        end
        check("dead_hit", {11'd0, hit}, 12'd1);
        check("dead_y", {1'b0, ghost_y}, 12'd868);
        drv(0, 0, 100, 100); settle();
        check("dead_bg", {draw_r, draw_g, draw_b}, 12'h800);
        frame(10, -1, -1); settle();
        check("dead_frozen", {1'b0, ghost_y}, 12'd868);

        frame(10, 4, -1); settle();
        check("restart_y", {1'b0, ghost_y}, 12'd434);
        check("restart_hit", {11'd0, hit}, 12'd0);

        frame(10, 8, -1); settle();
        check("same_cycle_flap", {1'b0, ghost_y}, 12'd424);
        frame(10, -1, -1); settle();
        check("pre_double", {1'b0, ghost_y}, 12'd415);
        frame(12, 2, 5); settle();
        check("double_flap", {1'b0, ghost_y}, 12'd405);

        repeat (45) frame(8, 1, -1);
        settle();
        check("ceiling_y", {1'b0, ghost_y}, 12'd0);
        check("ceiling_hit", {11'd0, hit}, 12'd0);
        frame(8, -1, -1); settle();
        check("after_ceiling", {1'b0, ghost_y}, 12'd1);

        frame(8, -1, -1);
        @(negedge clk);
        rst = 1'b1;
        settle();
        check("midplay_draw", {draw_r, draw_g, draw_b}, 12'h000);
        check("midplay_y", {1'b0, ghost_y}, 12'd434);
        check("midplay_hit", {11'd0, hit}, 12'd0);
        @(negedge clk);
        rst = 1'b0;

        repeat (300) begin
            int len = $urandom_range(6, 20);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                rst    = ($urandom_range(0, 399) == 0);
                vsync  = (i >= len - 2);
                flap   = ($urandom_range(0, 29) == 0);
                curr_x = 11'(rx());
                curr_y = 11'(ry());
            end
        end
        @(negedge clk);
        rst = 1'b0;
        settle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ghost_renderer.md
Name: ghost_renderer

Overview:
- Pixel-source end of the VGA draw interface: consumes the timing generator's pixel coordinates and vsync, and returns draw colours.
- Holds the player ghost's vertical physics (gravity, flap, floor/ceiling), updated once per frame on vsync.
- Renders the ghost sprite rectangle over a state-dependent background.
- Sits between the game input logic and the VGA output timing block.

Parameters:
- SCREEN_H, 900, visible lines; curr_y range 0..SCREEN_H-1
- GHOST_X, 200, left column of ghost
- GHOST_W, 32, ghost width in pixels
- GHOST_H, 32, ghost height in pixels
- START_Y, 434, ghost top row after reset / restart
- GRAV, 1, velocity increment per frame (pixels/frame)
- FLAP_V, 10, upward speed set on flap
- MAX_V, 12, downward velocity saturation

Ports:
- clk  in  1  pixel clock, same clock as the timing generator
- rst  in  1  synchronous reset, active-high
- curr_x  in  11  current pixel column from the timing generator
- curr_y  in  11  current pixel row from the timing generator
- vsync  in  1  timing-generator vsync, high during the sync pulse
- flap  in  1  debounced, clk-synchronous button level
- draw_r  out  4  red to timing generator
- draw_g  out  4  green to timing generator
- draw_b  out  4  blue to timing generator
- ghost_y  out  11  committed ghost top row
- hit  out  1  high while in DEAD

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, ghost_y=START_Y, vel=0, hit=0, draw_*=0
  - flap_pending=0, vsync_d=0, flap_d=0
- Frame tick: vsync & ~vsync_d. There is exactly one tick per frame; the tick falls in vertical blanking.
- Flap edge: flap & ~flap_d.
  - Sets flap_pending.
  - An edge in the same cycle as a tick is applied at that tick.
  - flap_pending clears at every tick.
  - Multiple edges within one frame count as one flap.
- vel: signed 8-bit, negative = up. ghost_y and vel change only at a tick; there is no mid-frame tearing.
- FSM, evaluated only at a tick:
  - IDLE: if a flap is pending, go to PLAY with vel=-FLAP_V and ghost_y=ghost_y-FLAP_V. Otherwise hold.
  - PLAY:
    - If a flap is pending, vel_n=-FLAP_V; otherwise vel_n=min(vel+GRAV, MAX_V).
    - Compute y_n=ghost_y+vel_n in 13-bit signed.
    - If y_n<0: ghost_y=0, vel=0 (ceiling, no death).
    - Else if y_n>=SCREEN_H-GHOST_H: ghost_y=SCREEN_H-GHOST_H, vel=0, go to DEAD, hit=1 in the same cycle.
    - Else: ghost_y=y_n, vel=vel_n.
  - DEAD: if a flap is pending, go to IDLE with ghost_y=START_Y, vel=0, hit=0. Otherwise hold frozen.
- Render (latency exactly 1 clk from curr_x/curr_y to draw_*):
  - in_ghost = GHOST_X<=curr_x<GHOST_X+GHOST_W and ghost_y<=curr_y<ghost_y+GHOST_H, with 12-bit unsigned compares and no wrap.
  - in_ghost=1: F,F,F.
  - Otherwise, DEAD: 8,0,0; IDLE/PLAY: 4,8,C.
  - Output is registered; blanking is handled downstream.
- Reset mid-frame or mid-flight: all state returns to the reset values on the next edge; draw_* is 0 on the cycle after reset.
- rst held: no ticks are processed.

Decomposition:
- Package ghost_pkg holds:
  - the state encoding (IDLE=0, PLAY=1, DEAD=2)
  - colour constants (SKY, GHOST, DEAD_BG)
  - the coordinate width constant 11
- One natural sub-module, ghost_physics: edge detectors, FSM, vel/ghost_y registers. It outputs state and ghost_y.
- The top level does the render compare and the output register.

Test Plan:
- Reset, then curr_x=210, curr_y=440 -> one clk later draw=F,F,F. With curr_x=100 -> 4,8,C. Also check ghost_y=434, hit=0.
- Flap pulse, then one tick -> state PLAY, ghost_y=424. Next tick with no flap -> vel=-9, ghost_y=415.
- No further flaps: count ticks until hit=1 -> ghost_y=868 (900-32) and vel=0. Background pixel reads 8,0,0; vel is never seen above 12.
- Flaps every tick from near the top -> ghost_y clamps at 0 and hit stays 0.
- Flap edge in the same cycle as the vsync rising edge -> applied at that tick. Two flap edges within one frame -> a single -FLAP_V.
- DEAD, flap, tick -> IDLE, ghost_y=434, hit=0. Assert rst mid-PLAY -> reset values next clk, draw=0.
